datapath_seq: RTL and testbench

//   Parametrised successor to the single-bus CPU datapath. It holds a register file, RY,
//   a 2*WIDTH-bit Z, and HI/LO around one shared bus and the ALU.
//   A built-in 3-step sequencer runs one register-transfer operation per start:
//   RY<-Ra, then Z<-op(RY,B), then writeback. It gives the control unit a start/done handshake.

---
 rtl/datapath_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
//
// Single-bus datapath with a built-in three-step sequencer. It contains a
// register file, the RY operand latch, a 2*WIDTH-bit Z result register and
// HI/LO, all arranged around one shared bus and the ALU.
//
// Each accepted start runs one register-transfer operation:
//   T_RY : bus = R[ra]                   RY <= bus
//   T_Z  : bus = use_imm ? imm : R[rb]   Z  <= alu(RY, bus)
//   T_WB : bus = Z[WIDTH-1:0]            MUL/DIV -> HI/LO, others -> R[rd]
// done pulses in the cycle after T_WB.
//
// Configuration macro: R0_ZERO_EN
//   defined   : R0 reads as 0 on the bus and on dbg_data; writes to R0 are dropped
//   undefined : R0 is an ordinary register
//
// Ports
//   clk          rising-edge clock
//   clear        synchronous active-high reset; aborts any operation in flight
//   start        request an operation (sampled only in IDLE)
//   opcode       ALU operation, captured with start
//   ra_sel       register driving RY
//   rb_sel       register used as operand B
//   rd_sel       writeback destination
//   use_imm      1: operand B is imm instead of R[rb_sel]
//   imm          immediate operand
//   ext_wr_en    external register load (honoured only in IDLE)
//   ext_wr_sel   external load target
//   ext_wr_data  external load value
//   dbg_sel      debug read select
//   dbg_data     combinational R[dbg_sel]
//   busy         high in T_RY, T_Z and T_WB
//   done         one-cycle pulse after writeback
//   hi_out       HI register
//   lo_out       LO register
//   bus_data     current bus value
// -----------------------------------------------------------------------------
module datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     start,
    input  logic [4:0]               opcode,
    input  logic [$clog2(NREGS)-1:0] ra_sel,
    input  logic [$clog2(NREGS)-1:0] rb_sel,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    input  logic                     use_imm,
    input  logic [WIDTH-1:0]         imm,
    input  logic                     ext_wr_en,
    input  logic [$clog2(NREGS)-1:0] ext_wr_sel,
    input  logic [WIDTH-1:0]         ext_wr_data,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [WIDTH-1:0]         dbg_data,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         hi_out,
    output logic [WIDTH-1:0]         lo_out,
    output logic [WIDTH-1:0]         bus_data
);

    localparam int SW  = $clog2(NREGS);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_DIV  = 5'd10;
    localparam logic [4:0] OP_NEG  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, T_RY, T_Z, T_WB} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   ry;
    logic [2*WIDTH-1:0] z;
    logic [2*WIDTH-1:0] alu_z;

    // Operation fields captured at the accepting edge
    logic [4:0]       op_q;
    logic [SW-1:0]    ra_q, rb_q, rd_q;
    logic             use_imm_q;
    logic [WIDTH-1:0] imm_q;

    logic             accept;
    logic             is_hilo;
    logic [WIDTH-1:0] ra_val, rb_val;
    logic             ext_wr_ok, wb_ok;

    assign accept  = (state == IDLE) && start;
    assign is_hilo = (op_q == OP_MUL) || (op_q == OP_DIV);

    // ---------------------------------------------------------------- reads
`ifdef R0_ZERO_EN
    assign ra_val    = (ra_q == '0)    ? '0 : regs[ra_q];
    assign rb_val    = (rb_q == '0)    ? '0 : regs[rb_q];
    assign dbg_data  = (dbg_sel == '0) ? '0 : regs[dbg_sel];
    assign ext_wr_ok = (ext_wr_sel != '0);
    assign wb_ok     = (rd_q != '0);
`else
    assign ra_val    = regs[ra_q];
    assign rb_val    = regs[rb_q];
    assign dbg_data  = regs[dbg_sel];
    assign ext_wr_ok = 1'b1;
    assign wb_ok     = 1'b1;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first keeps this combinational block
        // free of inferred latches on paths that do not assign.
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = T_RY;
            T_RY: state_next = T_Z;
            T_Z:  state_next = T_WB;
            T_WB: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        bus_data = '0;
        unique case (state)
            IDLE: bus_data = '0;
            T_RY: bus_data = ra_val;
            T_Z:  bus_data = use_imm_q ? imm_q : rb_val;
            T_WB: bus_data = z[WIDTH-1:0];
        endcase
    end

    // ---------------------------------------------------------------- ALU
    // Signed division done on magnitudes so the most-negative / -1 corner
    // never relies on host signed-division behaviour.
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b, div_b, q_mag, r_mag, quo, rem;

    always_comb begin
        a_neg  = ry[WIDTH-1];
        b_neg  = bus_data[WIDTH-1];
        b_zero = (bus_data == '0);
        abs_a  = a_neg ? -ry : ry;
        abs_b  = b_neg ? -bus_data : bus_data;
        div_b  = b_zero ? ONE : abs_b;
        q_mag  = abs_a / div_b;
        r_mag  = abs_a % div_b;
        if (b_zero) begin
            quo = '1;
            rem = ry;
        end else begin
            quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
            rem = a_neg ? -r_mag : r_mag;
        end
    end

    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rot;

    always_comb begin
        alu_z = '0;
        rot   = '0;
        shamt = bus_data[SHW-1:0];
        case (op_q)
            OP_ADD:  alu_z[WIDTH-1:0] = ry + bus_data;
            OP_SUB:  alu_z[WIDTH-1:0] = ry - bus_data;
            OP_AND:  alu_z[WIDTH-1:0] = ry & bus_data;
            OP_OR:   alu_z[WIDTH-1:0] = ry | bus_data;
            OP_SHR:  alu_z[WIDTH-1:0] = ry >> shamt;
            OP_SHRA: alu_z[WIDTH-1:0] = $signed(ry) >>> shamt;
            OP_SHL:  alu_z[WIDTH-1:0] = ry << shamt;
            OP_ROR: begin
                rot = {ry, ry} >> shamt;
                alu_z[WIDTH-1:0] = rot[WIDTH-1:0];
            end
            OP_ROL: begin
                rot = {ry, ry} << shamt;
                alu_z[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
            end
            // Sign-extended operands: the low 2W bits of the unsigned product
            // equal the signed product.
            OP_MUL:  alu_z = {{WIDTH{ry[WIDTH-1]}}, ry} *
                             {{WIDTH{bus_data[WIDTH-1]}}, bus_data};
            OP_DIV:  alu_z = {rem, quo};
            OP_NEG:  alu_z[WIDTH-1:0] = -ry;
            OP_NOT:  alu_z[WIDTH-1:0] = ~ry;
            default: alu_z = '0;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (clear) begin
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            ry        <= '0;
            z         <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= opcode;
                ra_q      <= ra_sel;
                rb_q      <= rb_sel;
                rd_q      <= rd_sel;
                use_imm_q <= use_imm;
                imm_q     <= imm;
            end
            if (state == T_RY) ry <= bus_data;
            if (state == T_Z)  z  <= alu_z;
            if (state == T_WB && is_hilo) begin
                hi_out <= z[2*WIDTH-1:WIDTH];
                lo_out <= z[WIDTH-1:0];
            end
            done <= (state == T_WB);
        end
    end

    // Register file. External loads only happen in IDLE and writeback only
    // in T_WB, so the two write ports never collide.
    always_ff @(posedge clk) begin
        // NOTE: the register file is deliberately cleared as a whole because
        // clear must leave every architectural register at zero.
        if (clear) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (state == IDLE && ext_wr_en && ext_wr_ok)
                regs[ext_wr_sel] <= ext_wr_data;
            if (state == T_WB && !is_hilo && wb_ok)
                regs[rd_q] <= z[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_seq
//
// Directed bench for datapath_seq (WIDTH=32, NREGS=16). A small reference
// model of the register file, HI/LO and ALU produces expected results that are
// queued when an operation is launched and compared when done pulses.
// Honours R0_ZERO_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_datapath_seq;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [3:0]  ra_sel, rb_sel, rd_sel;
    logic        use_imm;
    logic [31:0] imm;
    logic        ext_wr_en;
    logic [3:0]  ext_wr_sel;
    logic [31:0] ext_wr_data;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic        busy;
    logic        done;
    logic [31:0] hi_out, lo_out, bus_data;

    datapath_seq #(.WIDTH(32), .NREGS(16)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .ra_sel      (ra_sel),
        .rb_sel      (rb_sel),
        .rd_sel      (rd_sel),
        .use_imm     (use_imm),
        .imm         (imm),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_sel  (ext_wr_sel),
        .ext_wr_data (ext_wr_data),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .busy        (busy),
        .done        (done),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .bus_data    (bus_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } sb_entry_t;

    sb_entry_t sb [$];

    // Reference state
    logic [31:0] mreg [16];
    logic [31:0] mhi, mlo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] idx);
`ifdef R0_ZERO_EN
        if (idx == 4'd0) return 32'h0;
`endif
        return mreg[idx];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 32'h0;
        mhi = 32'h0;
        mlo = 32'h0;
    endfunction

    // Bit-serial reference ALU
    function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] t;
        int          sh;
        longint      p;
        int          ia, ib, q, r;
        t  = a;
        sh = int'(b[4:0]);
        case (op)
            5'd0:  return {32'h0, a + b};
            5'd1:  return {32'h0, a - b};
            5'd2:  return {32'h0, a & b};
            5'd3:  return {32'h0, a | b};
            5'd4:  begin for (int i = 0; i < sh; i++) t = {1'b0, t[31:1]};  return {32'h0, t}; end
            5'd5:  begin for (int i = 0; i < sh; i++) t = {t[31], t[31:1]}; return {32'h0, t}; end
            5'd6:  begin for (int i = 0; i < sh; i++) t = {t[30:0], 1'b0};  return {32'h0, t}; end
            5'd7:  begin for (int i = 0; i < sh; i++) t = {t[0], t[31:1]};  return {32'h0, t}; end
            5'd8:  begin for (int i = 0; i < sh; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
            5'd9:  begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            5'd10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                ia = a;
                ib = b;
                q  = ia / ib;
                r  = ia % ib;
                return {r, q};
            end
            5'd11: return {32'h0, 32'h0 - a};
            5'd12: return {32'h0, ~a};
            default: return 64'h0;
        endcase
    endfunction

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic ext_load(input logic [3:0] sel, input logic [31:0] data);
        @(negedge clk);
        ext_wr_en   = 1'b1;
        ext_wr_sel  = sel;
        ext_wr_data = data;
        @(negedge clk);
        ext_wr_en   = 1'b0;
        mreg[sel]   = data;
    endtask

    task automatic compare_head();
        sb_entry_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        dbg_sel = e.rd;
        #1;
        check({e.tag, "_rd"}, dbg_data, e.exp_rd);
        check({e.tag, "_hi"}, hi_out, e.exp_hi);
        check({e.tag, "_lo"}, lo_out, e.exp_lo);
    endtask

    // Launch one operation (optionally with a same-cycle external load and with
    // start held high for `hold` extra cycles), then watch an 8-cycle window.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [3:0] rd, input logic ui,
                          input logic [31:0] im, input int hold, input logic ew,
                          input logic [3:0] es, input logic [31:0] ed);
        sb_entry_t   e;
        logic [63:0] zr;
        int          busy_n  = 0;
        int          done_n  = 0;
        int          done_at = 0;

        if (ew) mreg[es] = ed;
        zr = model_alu(op, mread(ra), ui ? im : mread(rb));
        if (op == 5'd9 || op == 5'd10) begin
            mhi = zr[63:32];
            mlo = zr[31:0];
        end else begin
            mreg[rd] = zr[31:0];
        end
        e.tag    = tag;
        e.rd     = rd;
        e.exp_rd = mread(rd);
        e.exp_hi = mhi;
        e.exp_lo = mlo;
        sb.push_back(e);

        @(negedge clk);
        start       = 1'b1;
        opcode      = op;
        ra_sel      = ra;
        rb_sel      = rb;
        rd_sel      = rd;
        use_imm     = ui;
        imm         = im;
        ext_wr_en   = ew;
        ext_wr_sel  = es;
        ext_wr_data = ed;

        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble inputs to show the latched copy is what executes
                opcode    = 5'd31;
                ra_sel    = ~ra;
                rb_sel    = ~rb;
                rd_sel    = ~rd;
                use_imm   = ~ui;
                imm       = ~im;
                ext_wr_en = 1'b0;
            end
            start = (k <= hold);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_n == 1) begin
                    done_at = k;
                    compare_head();
                end
            end
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, busy_n, 3);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_cycle"}, done_at, 4);
    endtask

    initial begin
        int done_seen;

        clear       = 1'b1;
        start       = 1'b0;
        opcode      = '0;
        ra_sel      = '0;
        rb_sel      = '0;
        rd_sel      = '0;
        use_imm     = 1'b0;
        imm         = '0;
        ext_wr_en   = 1'b0;
        ext_wr_sel  = '0;
        ext_wr_data = '0;
        dbg_sel     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        clear = 1'b0;

        // Reset state
        dbg_sel = 4'd3;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        check("rst_bus", bus_data, 32'h0);
        check("rst_r3", dbg_data, 32'h0);

        // ADD 7 + 5 -> R3
        ext_load(4'd1, 32'd7);
        ext_load(4'd2, 32'd5);
        run_op("add", 5'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);

        // MUL -3 * 6 -> HI/LO, R4 untouched
        ext_load(4'd1, 32'hFFFF_FFFD);
        ext_load(4'd2, 32'd6);
        run_op("mul", 5'd9, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);

        // DIV cases
        ext_load(4'd1, 32'd17);
        ext_load(4'd2, 32'd5);
        run_op("div_pos", 5'd10, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        ext_load(4'd1, 32'hFFFF_FFEF);
        run_op("div_neg", 5'd10, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        ext_load(4'd1, 32'd17);
        ext_load(4'd2, 32'd0);
        run_op("div_zero", 5'd10, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);

        // Immediate shifts / rotates
        ext_load(4'd1, 32'h8000_0001);
        run_op("ror_imm", 5'd7, 4'd1, 4'd0, 4'd6, 1'b1, 32'd1, 0, 1'b0, 4'd0, 32'h0);
        ext_load(4'd1, 32'h8000_0000);
        run_op("shra_imm", 5'd5, 4'd1, 4'd0, 4'd7, 1'b1, 32'd36, 0, 1'b0, 4'd0, 32'h0);

        // Remaining ALU ops from registers
        ext_load(4'd9, 32'd1);
        ext_load(4'd12, 32'hF0F0_1234);
        ext_load(4'd13, 32'd35);
        run_op("sub_wrap", 5'd1, 4'd8, 4'd9, 4'd14, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("and", 5'd2, 4'd12, 4'd14, 4'd15, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("or", 5'd3, 4'd12, 4'd9, 4'd15, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("shr", 5'd4, 4'd12, 4'd13, 4'd5, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("shl", 5'd6, 4'd12, 4'd13, 4'd5, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("rol", 5'd8, 4'd12, 4'd0, 4'd5, 1'b1, 32'd44, 0, 1'b0, 4'd0, 32'h0);
        run_op("neg", 5'd11, 4'd12, 4'd9, 4'd5, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("not", 5'd12, 4'd12, 4'd9, 4'd5, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);
        run_op("undef_op", 5'd20, 4'd12, 4'd9, 4'd3, 1'b0, 32'h0, 0, 1'b0, 4'd0, 32'h0);

        // External load in the start cycle, rd == ra == rb
        run_op("ext_start", 5'd0, 4'd10, 4'd10, 4'd10, 1'b0, 32'h0, 0, 1'b1, 4'd10, 32'd21);

        // start held through busy: exactly one operation
        ext_load(4'd1, 32'd100);
        ext_load(4'd2, 32'd23);
        run_op("start_busy", 5'd0, 4'd1, 4'd2, 4'd11, 1'b0, 32'h0, 2, 1'b0, 4'd0, 32'h0);

        // clear in T_Z aborts the operation
        @(negedge clk);
        start   = 1'b1;
        opcode  = 5'd0;
        ra_sel  = 4'd1;
        rb_sel  = 4'd2;
        rd_sel  = 4'd6;
        use_imm = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        dbg_sel = 4'd1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi_out, 32'h0);
        check("abort_lo", lo_out, 32'h0);
        check("abort_bus", bus_data, 32'h0);
        check("abort_r1", dbg_data, 32'h0);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        dbg_sel = 4'd6;
        #1;
        check("abort_r6", dbg_data, 32'h0);

        // R0 behaviour
        ext_load(4'd0, 32'd5);
        dbg_sel = 4'd0;
        #1;
`ifdef R0_ZERO_EN
        check("r0_read", dbg_data, 32'd0);
`else
        check("r0_read", dbg_data, 32'd5);
`endif

        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
